srff_bank: RTL and testbench

Parametrised bank of clocked set/reset flip-flops with selectable set/reset priority, optional rising-edge event capture, sticky overflow flags, a software clear mask and a read-and-clear snapshot port. It latches asynchronous-rate event strobes from peripherals into status bits that the CPU bus interface reads and clears. An optional masked interrupt output is provided. One instance replaces a row of single-bit SR flip-flops and their ad-hoc glue.

---
 rtl/srff_bank.sv | 103 ++++++++++
 tb/tb_srff_bank.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/srff_bank.sv
// Bank of clocked set/reset flip-flops with sticky overflow, software clear and read-and-clear snapshot.
// Define SRFF_BANK_IRQ_EN to build the interrupt mask register and the masked irq output.
module srff_lane #(
    parameter int SET_PRIORITY = 0,
    parameter int EDGE_MODE    = 0,
    parameter bit INIT_BIT     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic s,
    input  logic r,
    input  logic clr,
    input  logic rd_stb,
    output logic q,
    output logic ovf
);
    logic s_d;
    logic se;
    logic sc;

    assign se = (EDGE_MODE != 0) ? (s & ~s_d) : s;
    // A read-and-clear only drops bits that are currently set.
    assign sc = clr | (rd_stb & q);

    always_ff @(posedge clk) begin
        if (rst) begin
            q   <= INIT_BIT;
            ovf <= 1'b0;
            s_d <= s;
        end else begin
            s_d <= s;
            if (se && r)     q <= (SET_PRIORITY != 0);
            else if (se)     q <= 1'b1;
            else if (r || sc) q <= 1'b0;
            // A read-and-clear does not hide an event lost on a set bit.
            if (clr)                 ovf <= 1'b0;
            else if (se && q && !r)  ovf <= 1'b1;
        end
    end
endmodule

module srff_bank #(
    parameter int               WIDTH        = 8,
    parameter int               SET_PRIORITY = 0,
    parameter int               EDGE_MODE    = 0,
    parameter logic [WIDTH-1:0] INIT         = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] clr,
    input  logic             rd_stb,
    input  logic             mask_we,
    input  logic [WIDTH-1:0] mask_d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] ovf,
    output logic             irq
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        srff_lane #(
            .SET_PRIORITY(SET_PRIORITY),
            .EDGE_MODE   (EDGE_MODE),
            .INIT_BIT    (INIT[i])
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .s     (s[i]),
            .r     (r[i]),
            .clr   (clr[i]),
            .rd_stb(rd_stb),
            .q     (q[i]),
            .ovf   (ovf[i])
        );
    end

    assign qn = ~q;

    always_ff @(posedge clk) begin
        if (rst)         rd_data <= '0;
        else if (rd_stb) rd_data <= q;
    end

`ifdef SRFF_BANK_IRQ_EN
    logic [WIDTH-1:0] mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            mask <= '0;
            irq  <= 1'b0;
        end else begin
            if (mask_we) mask <= mask_d;
            irq <= |(q & mask);
        end
    end
`else
    logic unused_mask;
    assign unused_mask = ^{mask_we, mask_d};
    assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_srff_bank.sv
// Self-checking bench: four parameter combinations driven in parallel, directed tables plus random vs. a reference model.
module tb_srff_bank;
`ifdef SRFF_BANK_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif
    localparam logic [7:0] INIT = 8'hA5;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s, r, clr, mask_d;
    logic       rd_stb, mask_we;

    logic [7:0] q_o [4];
    logic [7:0] qn_o [4];
    logic [7:0] rd_o [4];
    logic [7:0] ovf_o [4];
    logic       irq_o [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // cfg index c: SET_PRIORITY = c[1], EDGE_MODE = c[0]
    for (genvar g = 0; g < 4; g++) begin : g_dut
        srff_bank #(.WIDTH(8), .SET_PRIORITY(g / 2), .EDGE_MODE(g % 2), .INIT(INIT)) u_dut (
            .clk(clk), .rst(rst), .s(s), .r(r), .clr(clr), .rd_stb(rd_stb),
            .mask_we(mask_we), .mask_d(mask_d),
            .q(q_o[g]), .qn(qn_o[g]), .rd_data(rd_o[g]), .ovf(ovf_o[g]), .irq(irq_o[g])
        );
    end

    // Reference model state
    logic [7:0] m_q [4], m_ovf [4], m_rd [4], m_mask [4], m_sd [4];
    logic       m_irq [4];

    task automatic chk(input string name, input int c, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cfg%0d got %h expected %h at %0t", name, c, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        for (int c = 0; c < 4; c++) begin
            bit sp, em;
            logic [7:0] nq, novf;
            sp = c[1];
            em = c[0];
            if (rst) begin
                m_q[c] = INIT; m_ovf[c] = '0; m_rd[c] = '0; m_mask[c] = '0; m_irq[c] = 1'b0;
            end else begin
                nq = m_q[c];
                novf = m_ovf[c];
                for (int i = 0; i < 8; i++) begin
                    bit ev, swclr;
                    ev = em ? (s[i] && !m_sd[c][i]) : s[i];
                    swclr = clr[i] || (rd_stb && m_q[c][i]);
                    if (ev && r[i])         nq[i] = sp;
                    else if (ev)            nq[i] = 1'b1;
                    else if (r[i] || swclr) nq[i] = 1'b0;
                    if (clr[i])                        novf[i] = 1'b0;
                    else if (ev && m_q[c][i] && !r[i]) novf[i] = 1'b1;
                end
                m_irq[c] = IRQ_ON && ((m_q[c] & m_mask[c]) != 0);
                if (mask_we) m_mask[c] = mask_d;
                if (rd_stb) m_rd[c] = m_q[c];
                m_q[c] = nq;
                m_ovf[c] = novf;
            end
            m_sd[c] = s;
        end
    endtask

    task automatic step(input logic rs, input logic [7:0] sv, input logic [7:0] rv, input logic [7:0] cv,
                        input logic rdv, input logic mwe, input logic [7:0] md);
        @(negedge clk);
        rst = rs; s = sv; r = rv; clr = cv; rd_stb = rdv; mask_we = mwe; mask_d = md;
        @(posedge clk);
        model_edge();
        #1;
        for (int c = 0; c < 4; c++) begin
            chk("q", c, q_o[c], m_q[c]);
            chk("qn", c, qn_o[c], ~m_q[c]);
            chk("ovf", c, ovf_o[c], m_ovf[c]);
            chk("rd_data", c, rd_o[c], m_rd[c]);
            chk("irq", c, {7'd0, irq_o[c]}, {7'd0, m_irq[c]});
        end
    endtask

    typedef struct {
        logic [7:0] s, r, clr;
        logic       rd;
        int         cfg;
        logic [7:0] eq, eovf, erd;
    } vec_t;

    vec_t vecs [24];
    logic irq_exp [6];

    initial begin
        vecs = '{
            '{8'hFF, 8'h00, 8'h00, 1'b0, 1, 8'hA5, 8'h00, 8'h00},  // held s after reset: no edge
            '{8'h00, 8'hFF, 8'hFF, 1'b0, 1, 8'h00, 8'h00, 8'h00},
            '{8'h01, 8'h01, 8'h00, 1'b0, 0, 8'h00, 8'h00, 8'h00},  // reset wins
            '{8'h01, 8'h01, 8'h00, 1'b0, 2, 8'h01, 8'h00, 8'h00},  // set wins
            '{8'h00, 8'h00, 8'hFF, 1'b0, 0, 8'h00, 8'h00, 8'h00},
            '{8'h03, 8'h00, 8'h00, 1'b0, 0, 8'h03, 8'h00, 8'h00},
            '{8'h01, 8'h00, 8'h00, 1'b1, 0, 8'h01, 8'h01, 8'h03},  // read-clear vs new event
            '{8'h00, 8'h00, 8'h00, 1'b1, 0, 8'h00, 8'h01, 8'h01},  // back-to-back read
            '{8'h00, 8'h00, 8'h00, 1'b1, 0, 8'h00, 8'h01, 8'h00},
            '{8'h00, 8'h00, 8'hFF, 1'b0, 1, 8'h00, 8'h00, 8'h00},
            '{8'h04, 8'h00, 8'h00, 1'b0, 1, 8'h04, 8'h00, 8'h00},  // edge mode, s[2] high 5 cycles
            '{8'h04, 8'h00, 8'h00, 1'b0, 1, 8'h04, 8'h00, 8'h00},
            '{8'h04, 8'h00, 8'h00, 1'b0, 1, 8'h04, 8'h00, 8'h00},
            '{8'h04, 8'h00, 8'h00, 1'b0, 1, 8'h04, 8'h00, 8'h00},
            '{8'h04, 8'h00, 8'h00, 1'b0, 1, 8'h04, 8'h00, 8'h00},
            '{8'h04, 8'h00, 8'h04, 1'b0, 1, 8'h00, 8'h00, 8'h00},
            '{8'h04, 8'h00, 8'h00, 1'b0, 1, 8'h00, 8'h00, 8'h00},  // still high: not re-set
            '{8'h00, 8'h00, 8'h00, 1'b0, 1, 8'h00, 8'h00, 8'h00},
            '{8'h04, 8'h00, 8'h00, 1'b0, 1, 8'h04, 8'h00, 8'h00},
            '{8'h00, 8'h00, 8'hFF, 1'b0, 0, 8'h00, 8'h00, 8'h00},
            '{8'h80, 8'h00, 8'h00, 1'b0, 0, 8'h80, 8'h00, 8'h00},
            '{8'h00, 8'h00, 8'h00, 1'b0, 0, 8'h80, 8'h00, 8'h00},
            '{8'h80, 8'h00, 8'h00, 1'b0, 0, 8'h80, 8'h80, 8'h00},  // lost event
            '{8'h80, 8'h00, 8'h80, 1'b0, 0, 8'h80, 8'h00, 8'h00}   // clr vs event
        };
        irq_exp = '{1'b0, IRQ_ON, IRQ_ON, 1'b0, 1'b0, 1'b0};

        // Reset with s held high
        step(1'b1, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
        step(1'b1, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
        for (int c = 0; c < 4; c++) begin
            chk("rst_q", c, q_o[c], 8'hA5);
            chk("rst_qn", c, qn_o[c], 8'h5A);
            chk("rst_ovf", c, ovf_o[c], 8'h00);
            chk("rst_rd", c, rd_o[c], 8'h00);
            chk("rst_irq", c, {7'd0, irq_o[c]}, 8'h00);
        end

        for (int k = 0; k < 24; k++) begin
            step(1'b0, vecs[k].s, vecs[k].r, vecs[k].clr, vecs[k].rd, 1'b0, 8'h00);
            chk($sformatf("vec%0d_q", k), vecs[k].cfg, q_o[vecs[k].cfg], vecs[k].eq);
            chk($sformatf("vec%0d_ovf", k), vecs[k].cfg, ovf_o[vecs[k].cfg], vecs[k].eovf);
            chk($sformatf("vec%0d_rd", k), vecs[k].cfg, rd_o[vecs[k].cfg], vecs[k].erd);
        end

        // Interrupt: mask bit 4, s[4] pulse, clear, then unmasked s[3] pulse
        step(1'b0, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 8'h00);
        step(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h10);
        step(1'b0, 8'h10, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
        chk("irq_same_cycle", 0, {7'd0, irq_o[0]}, {7'd0, irq_exp[0]});
        step(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
        chk("irq_next_cycle", 0, {7'd0, irq_o[0]}, {7'd0, irq_exp[1]});
        step(1'b0, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0, 8'h00);
        chk("irq_during_clr", 0, {7'd0, irq_o[0]}, {7'd0, irq_exp[2]});
        step(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
        chk("irq_after_clr", 0, {7'd0, irq_o[0]}, {7'd0, irq_exp[3]});
        step(1'b0, 8'h08, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
        chk("irq_unmasked_a", 0, {7'd0, irq_o[0]}, {7'd0, irq_exp[4]});
        step(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
        chk("irq_unmasked_b", 0, {7'd0, irq_o[0]}, {7'd0, irq_exp[5]});

        // Random traffic, sparse r/clr so bits accumulate and overflow
        for (int k = 0; k < 600; k++) begin
            logic       rs;
            logic [7:0] rv, cv;
            rs = ($urandom_range(0, 63) == 0);
            rv = 8'($urandom) & 8'($urandom) & 8'($urandom);
            cv = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            step(rs, 8'($urandom), rv, cv, ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 7) == 0), 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
